area_sqrt: RTL and testbench



---
 rtl/area_sqrt_pkg.sv | 15 +
 rtl/area_sqrt_step.sv | 32 +++
 rtl/area_sqrt.sv | 96 +++++++++
 tb/tb_area_sqrt.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/area_sqrt_pkg.sv
// Shared definitions for the area square-root stage: default widths and FSM states.
package area_sqrt_pkg;

   localparam int unsigned W_IN_DEF  = 16;
   localparam int unsigned W_OUT_DEF = W_IN_DEF / 2;
   localparam int unsigned W_CNT     = 4;

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_CALC     = 2'b01,
      S_WAIT_RFD = 2'b10,
      S_OFFER    = 2'b11
   } state_t;

endpackage

// File: rtl/area_sqrt_step.sv
// One digit-by-digit square-root step: consumes two radicand bits, produces one root bit.
module area_sqrt_step
   import area_sqrt_pkg::*;
#(
   parameter int unsigned W_OUT = W_OUT_DEF
) (
   input  logic [W_OUT+1:0] rem,
   input  logic [W_OUT-1:0] root,
   input  logic [1:0]       x_top,
   output logic [W_OUT+1:0] rem_nxt_c,
   output logic [W_OUT-1:0] root_nxt_c
);

   localparam int unsigned W_R = W_OUT + 4;

   logic [W_R-1:0] r;
   logic [W_R-1:0] t;

   // Trial subtraction; the running remainder stays <= 2*root, so it fits back in W_OUT+2 bits.
   always_comb begin
      r = {rem, x_top};
      t = W_R'({root, 2'b01});
      if (r >= t) begin
         rem_nxt_c  = (W_OUT+2)'(r - t);
         root_nxt_c = {root[W_OUT-2:0], 1'b1};
      end else begin
         rem_nxt_c  = (W_OUT+2)'(r);
         root_nxt_c = {root[W_OUT-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/area_sqrt.sv
// Iterative integer square root of the rectangle area with /dav-rfd handshakes on both sides.
module area_sqrt
   import area_sqrt_pkg::*;
#(
   parameter int unsigned W_IN  = W_IN_DEF,
   parameter int unsigned W_OUT = W_IN / 2
) (
   input  logic             clock,
   input  logic             reset_,
   input  logic [W_IN-1:0]  data_in,
   input  logic             dav_in_,
   output logic             rfd_in,
   output logic [W_OUT-1:0] data_out,
   output logic [W_OUT:0]   rem_out,
   output logic             dav_out_,
   input  logic             rfd_out
);

   state_t           state, state_nxt;
   logic [W_IN-1:0]  x, x_nxt;
   logic [W_OUT+1:0] rem, rem_nxt, rem_step_c;
   logic [W_OUT-1:0] root, root_nxt, root_step_c;
   logic [W_CNT-1:0] count, count_nxt;
   logic             rfd_nxt, dav_nxt;

   area_sqrt_step #(
      .W_OUT (W_OUT)
   ) u_step (
      .rem        (rem),
      .root       (root),
      .x_top      (x[W_IN-1:W_IN-2]),
      .rem_nxt_c  (rem_step_c),
      .root_nxt_c (root_step_c)
   );

   // Next-state and datapath selection; handshake outputs follow the next state.
   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      rem_nxt   = rem;
      root_nxt  = root;
      count_nxt = count;
      case (state)
         S_IDLE: begin
            if (!dav_in_) begin
               x_nxt     = data_in;
               rem_nxt   = '0;
               root_nxt  = '0;
               count_nxt = W_CNT'(W_OUT);
               state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            x_nxt     = {x[W_IN-3:0], 2'b00};
            rem_nxt   = rem_step_c;
            root_nxt  = root_step_c;
            count_nxt = count - W_CNT'(1);
            if (count == W_CNT'(1)) state_nxt = S_WAIT_RFD;
         end
         S_WAIT_RFD: begin
            if (rfd_out) state_nxt = S_OFFER;
         end
         S_OFFER: begin
            // Hold the offer until the producer has released dav_in_ so stale data is not re-sampled.
            if (!rfd_out && dav_in_) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      rfd_nxt = (state_nxt == S_IDLE);
      dav_nxt = (state_nxt != S_OFFER);
   end

   always_ff @(posedge clock) begin
      if (reset_) begin
         state    <= S_IDLE;
         rfd_in   <= 1'b1;
         dav_out_ <= 1'b1;
         x        <= '0;
         rem      <= '0;
         root     <= '0;
         count    <= '0;
      end else begin
         state    <= state_nxt;
         rfd_in   <= rfd_nxt;
         dav_out_ <= dav_nxt;
         x        <= x_nxt;
         rem      <= rem_nxt;
         root     <= root_nxt;
         count    <= count_nxt;
      end
   end

   assign data_out = root;
   assign rem_out  = (W_OUT+1)'(rem);

endmodule

// File: tb/tb_area_sqrt.sv
// Scoreboard bench for area_sqrt: directed handshake/boundary cases plus a randomized traffic run.
module tb_area_sqrt;

   logic        clock    = 1'b0;
   logic        reset_   = 1'b1;
   logic [15:0] data_in  = '0;
   logic        dav_in_  = 1'b1;
   logic        rfd_in;
   logic [7:0]  data_out;
   logic [8:0]  rem_out;
   logic        dav_out_;
   logic        rfd_out  = 1'b0;

   typedef struct {
      logic [15:0] area;
      logic [7:0]  root;
      logic [8:0]  rem;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;
   int   checks = 0;
   int   errors = 0;
   logic prev_dav = 1'b1;

   area_sqrt dut (
      .clock    (clock),
      .reset_   (reset_),
      .data_in  (data_in),
      .dav_in_  (dav_in_),
      .rfd_in   (rfd_in),
      .data_out (data_out),
      .rem_out  (rem_out),
      .dav_out_ (dav_out_),
      .rfd_out  (rfd_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_rfd_in(input int budget);
      int n = 0;
      while (rfd_in !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      if (rfd_in !== 1'b1) check("rfd_in timeout", 32'(rfd_in), 1);
   endtask

   task automatic wait_dav_out(input logic val, input int budget);
      int n = 0;
      while (dav_out_ !== val && n < budget) begin
         tick();
         n++;
      end
      if (dav_out_ !== val) check("dav_out_ timeout", 32'(dav_out_), 32'(val));
   endtask

   function automatic exp_t model(input logic [15:0] a);
      exp_t e;
      int   r = 0;
      while ((r + 1) * (r + 1) <= int'(a)) r++;
      e.area = a;
      e.root = 8'(r);
      e.rem  = 9'(int'(a) - r * r);
      return e;
   endfunction

   task automatic send(input logic [15:0] a, input logic [7:0] root, input logic [8:0] rem);
      exp_t e;
      wait_rfd_in(200);
      e.area = a;
      e.root = root;
      e.rem  = rem;
      sb.push_back(e);
      data_in = a;
      dav_in_ = 1'b0;
      tick();
      check("rfd_in falls after sample", 32'(rfd_in), 0);
      dav_in_ = 1'b1;
   endtask

   task automatic xact(input logic [15:0] a, input logic [7:0] root, input logic [8:0] rem);
      send(a, root, rem);
      rfd_out = 1'b1;
      wait_dav_out(1'b0, 50);
      rfd_out = 1'b0;
      wait_rfd_in(50);
   endtask

   // Monitor: compare against the scoreboard each time a new result is offered.
   always @(negedge clock) begin
      if (reset_) begin
         prev_dav = 1'b1;
      end else begin
         if (!dav_out_ && prev_dav) begin
            if (sb.size() == 0) begin
               check("unexpected offer", 32'(1), 32'(0));
            end else begin
               e_mon = sb.pop_front();
               check("root", 32'(data_out), 32'(e_mon.root));
               check("rem", 32'(rem_out), 32'(e_mon.rem));
               check("root^2+rem", 32'(data_out) * 32'(data_out) + 32'(rem_out), 32'(e_mon.area));
               check("rem<=2*root", 32'(rem_out > {data_out, 1'b0}), 32'(0));
            end
         end
         prev_dav = dav_out_;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t e;
      reset_ = 1'b1;
      tick(2);
      check("reset rfd_in", 32'(rfd_in), 1);
      check("reset dav_out_", 32'(dav_out_), 1);
      check("reset data_out", 32'(data_out), 0);
      check("reset rem_out", 32'(rem_out), 0);
      reset_ = 1'b0;
      tick();

      // area=400, consumer ready early: offer appears one cycle after the 8th calc cycle
      send(16'd400, 8'd20, 9'd0);
      rfd_out = 1'b1;
      tick(8);
      check("400 dav_out_ after calc", 32'(dav_out_), 1);
      check("400 data_out final", 32'(data_out), 20);
      check("400 rem_out final", 32'(rem_out), 0);
      tick();
      check("400 dav_out_ falls", 32'(dav_out_), 0);
      rfd_out = 1'b0;
      tick();
      check("400 back to idle rfd_in", 32'(rfd_in), 1);
      check("400 back to idle dav_out_", 32'(dav_out_), 1);

      xact(16'hFFFF, 8'hFF, 9'h1FE);
      xact(16'd0, 8'd0, 9'd0);
      xact(16'd2, 8'd1, 9'd1);
      xact(16'd1, 8'd1, 9'd0);

      // Consumer stalls 20 cycles with rfd_out low
      send(16'd1000, 8'd31, 9'd39);
      tick(8);
      for (int i = 0; i < 20; i++) begin
         check("stall dav_out_", 32'(dav_out_), 1);
         check("stall rfd_in", 32'(rfd_in), 0);
         check("stall data_out", 32'(data_out), 31);
         check("stall rem_out", 32'(rem_out), 39);
         tick();
      end
      rfd_out = 1'b1;
      tick();
      check("stall release dav_out_", 32'(dav_out_), 0);
      rfd_out = 1'b0;
      tick();
      check("stall done rfd_in", 32'(rfd_in), 1);

      // Producer keeps dav_in_ low through the whole transaction
      wait_rfd_in(50);
      e.area = 16'd144;
      e.root = 8'd12;
      e.rem  = 9'd0;
      sb.push_back(e);
      data_in = 16'd144;
      dav_in_ = 1'b0;
      rfd_out = 1'b1;
      wait_dav_out(1'b0, 30);
      rfd_out = 1'b0;
      tick(3);
      check("held dav_in_ stays offered", 32'(dav_out_), 0);
      check("held dav_in_ rfd_in low", 32'(rfd_in), 0);
      dav_in_ = 1'b1;
      tick();
      check("held release rfd_in", 32'(rfd_in), 1);
      check("held release dav_out_", 32'(dav_out_), 1);

      // Reset during the 4th calc cycle
      send(16'd50000, 8'd223, 9'd271);
      tick(3);
      reset_ = 1'b1;
      tick();
      check("midreset rfd_in", 32'(rfd_in), 1);
      check("midreset dav_out_", 32'(dav_out_), 1);
      check("midreset data_out", 32'(data_out), 0);
      check("midreset rem_out", 32'(rem_out), 0);
      sb.delete();
      reset_ = 1'b0;
      tick();
      xact(16'd81, 8'd9, 9'd0);

      // Random back-to-back traffic with random producer/consumer delays
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               logic [15:0] a;
               exp_t        ep;
               a  = 16'($urandom);
               ep = model(a);
               repeat ($urandom_range(0, 5)) tick();
               send(a, ep.root, ep.rem);
            end
         end
         begin
            for (int j = 0; j < 1000; j++) begin
               repeat ($urandom_range(0, 5)) tick();
               rfd_out = 1'b1;
               wait_dav_out(1'b0, 200);
               rfd_out = 1'b0;
               wait_dav_out(1'b1, 50);
            end
         end
      join

      tick(5);
      check("scoreboard drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
